// File: rtl/editor_dia_bcd_pkg.sv
// Shared types, BCD constants and day-limit helpers for the day editor.
package editor_dia_bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EDIT  = 2'd1,
    ST_WRITE = 2'd2
  } estado_t;

  localparam logic [7:0] BCD_01 = 8'h01;
  localparam logic [7:0] BCD_28 = 8'h28;
  localparam logic [7:0] BCD_29 = 8'h29;
  localparam logic [7:0] BCD_30 = 8'h30;
  localparam logic [7:0] BCD_31 = 8'h31;

  // BCD year divisible by 4: even tens need units 0/4/8, odd tens need 2/6.
  function automatic logic bcd_bisiesto(input logic [7:0] anio);
    if (anio[4]) return (anio[3:0] == 4'd2) || (anio[3:0] == 4'd6);
    return (anio[3:0] == 4'd0) || (anio[3:0] == 4'd4) || (anio[3:0] == 4'd8);
  endfunction

  function automatic logic [7:0] limite_mes(input logic [7:0] mes, input logic [7:0] anio);
    case (mes)
      8'h04, 8'h06, 8'h09, 8'h11: return BCD_30;
      8'h02:                      return bcd_bisiesto(anio) ? BCD_29 : BCD_28;
      default:                    return BCD_31;
    endcase
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v >= max) return BCD_01;
    if (v[3:0] >= 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
    if ((v <= BCD_01) || (v > max)) return max;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

endpackage

// File: rtl/editor_dia_bcd_if.sv
// Signal bundle between the day editor and its environment (RTC, buttons, display).
interface editor_dia_bcd_if;
  logic       seleccion;
  logic       btn_up;
  logic       btn_down;
  logic [7:0] dia_rtc;
  logic [7:0] mes;
  logic [7:0] anio;
  logic       wr_ack;
  logic [7:0] dseg;
  logic       ACT;
  logic       wr_req;
  logic       edit_activo;

  modport master (
    output seleccion, btn_up, btn_down, dia_rtc, mes, anio, wr_ack,
    input  dseg, ACT, wr_req, edit_activo
  );

  modport slave (
    input  seleccion, btn_up, btn_down, dia_rtc, mes, anio, wr_ack,
    output dseg, ACT, wr_req, edit_activo
  );
endinterface

// File: rtl/editor_dia_bcd_repetidor_boton.sv
// Button edge detector with hold-to-repeat down-counter; emits a one-cycle step pulse.
module repetidor_boton #(
  parameter int unsigned REPEAT_DELAY = 50_000_000,
  parameter int unsigned REPEAT_RATE  = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic habilita,
  input  logic btn,
  input  logic bloqueo,
  output logic paso
);

  localparam int unsigned CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CARGA_DELAY = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] CARGA_RATE  = CW'(REPEAT_RATE - 1);

  logic          btn_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flanco, vence;

  always_comb begin
    flanco = btn & ~btn_q;
    vence  = btn & btn_q & (cnt_q == '0);
    paso   = habilita & ~bloqueo & (flanco | vence);

    cnt_d = cnt_q;
    // Any idle, released or both-pressed cycle rearms the initial hold delay.
    if (!habilita || !btn || bloqueo || flanco) cnt_d = CARGA_DELAY;
    else if (cnt_q == '0)                       cnt_d = CARGA_RATE;
    else                                        cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      btn_q <= btn;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/editor_dia_bcd.sv
// Day-of-month BCD editor: tracks the RTC, lets the user step the day, writes it back.
// Define MES_LIMITE_EN to limit the day range by month/leap year; otherwise max is 31.
//
// state    | meaning
// ST_IDLE  | dseg follows dia_rtc every cycle
// ST_EDIT  | buttons step dseg, ACT strobes each change
// ST_WRITE | wr_req held, dseg frozen until wr_ack
module editor_dia_bcd
  import editor_dia_bcd_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY = 50_000_000,
  parameter int unsigned REPEAT_RATE  = 10_000_000
) (
  input  logic             clk,
  input  logic             reset,
  editor_dia_bcd_if.slave  bus
);

  estado_t    estado_q;
  logic [7:0] dseg_q;
  logic       act_q;
  logic       wr_req_q;
  logic       edit_q;
  logic [7:0] dia_max;
  logic       habilita;
  logic       paso_up, paso_dn;

`ifdef MES_LIMITE_EN
  assign dia_max = limite_mes(bus.mes, bus.anio);
`else
  assign dia_max = BCD_31;
`endif

  assign habilita = (estado_q == ST_EDIT);

  repetidor_boton #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_rep_up (
    .clk      (clk),
    .reset    (reset),
    .habilita (habilita),
    .btn      (bus.btn_up),
    .bloqueo  (bus.btn_down),
    .paso     (paso_up)
  );

  repetidor_boton #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_rep_dn (
    .clk      (clk),
    .reset    (reset),
    .habilita (habilita),
    .btn      (bus.btn_down),
    .bloqueo  (bus.btn_up),
    .paso     (paso_dn)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= ST_IDLE;
      dseg_q   <= BCD_01;
      act_q    <= 1'b0;
      wr_req_q <= 1'b0;
      edit_q   <= 1'b0;
    end else begin
      act_q <= 1'b0;
      case (estado_q)
        ST_IDLE: begin
          dseg_q   <= bus.dia_rtc;
          wr_req_q <= 1'b0;
          if (bus.seleccion) begin
            estado_q <= ST_EDIT;
            edit_q   <= 1'b1;
          end
        end
        ST_EDIT: begin
          // Leaving edit takes priority: a step seen in the same cycle is discarded.
          if (!bus.seleccion) begin
            estado_q <= ST_WRITE;
            edit_q   <= 1'b0;
            wr_req_q <= 1'b1;
          end else if (paso_up) begin
            dseg_q <= bcd_inc(dseg_q, dia_max);
            act_q  <= 1'b1;
          end else if (paso_dn) begin
            dseg_q <= bcd_dec(dseg_q, dia_max);
            act_q  <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (bus.wr_ack) begin
            estado_q <= ST_IDLE;
            wr_req_q <= 1'b0;
          end
        end
        default: begin
          estado_q <= ST_IDLE;
          wr_req_q <= 1'b0;
          edit_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dseg        = dseg_q;
  assign bus.ACT         = act_q;
  assign bus.wr_req      = wr_req_q;
  assign bus.edit_activo = edit_q;

endmodule

// File: tb/tb_editor_dia_bcd.sv
// Self-checking bench for editor_dia_bcd: scoreboard of expected day values popped on each ACT strobe.
module tb_editor_dia_bcd;

  localparam int RD = 10;
  localparam int RR = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  editor_dia_bcd_if bus();

  editor_dia_bcd #(.REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] sb[$];
  logic [7:0] mdl_dseg;

  function automatic int bcd2int(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(input int d);
    return {4'(d / 10), 4'(d % 10)};
  endfunction

  function automatic int mdl_max(input logic [7:0] m, input logic [7:0] a);
`ifdef MES_LIMITE_EN
    int mm;
    int yy;
    mm = bcd2int(m);
    yy = bcd2int(a);
    if (mm == 2) return (yy % 4 == 0) ? 29 : 28;
    if (mm == 4 || mm == 6 || mm == 9 || mm == 11) return 30;
    return 31;
`else
    return 31;
`endif
  endfunction

  function automatic logic [7:0] mdl_step(input logic [7:0] v, input bit up, input int mx);
    int d;
    d = bcd2int(v);
    if (up) d = (d >= mx) ? 1 : d + 1;
    else    d = (d <= 1 || d > mx) ? mx : d - 1;
    return int2bcd(d);
  endfunction

  // Every ACT strobe must match the oldest expected value.
  always @(negedge clk) begin : monitor
    logic [7:0] e;
    if (bus.ACT === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL act_unexpected dseg=%h expected=no_strobe", bus.dseg);
      end else begin
        e = sb.pop_front();
        if (bus.dseg !== e) begin
          failures++;
          $display("FAIL sb_dseg got=%h exp=%h", bus.dseg, e);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic press(input bit up);
    if (up) bus.btn_up = 1'b1;
    else    bus.btn_down = 1'b1;
    mdl_dseg = mdl_step(mdl_dseg, up, mdl_max(bus.mes, bus.anio));
    sb.push_back(mdl_dseg);
    tick;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    bus.seleccion = 1'b0;
    bus.btn_up    = 1'b0;
    bus.btn_down  = 1'b0;
    bus.dia_rtc   = 8'h15;
    bus.mes       = 8'h01;
    bus.anio      = 8'h24;
    bus.wr_ack    = 1'b0;
    reset = 1'b1;
    tick;
    tick;
    checks++; if (bus.dseg !== 8'h01) begin failures++; $display("FAIL reset_dseg got=%h exp=01", bus.dseg); end
    checks++; if (bus.ACT !== 1'b0) begin failures++; $display("FAIL reset_act got=%b exp=0", bus.ACT); end
    checks++; if (bus.wr_req !== 1'b0) begin failures++; $display("FAIL reset_wr_req got=%b exp=0", bus.wr_req); end
    checks++; if (bus.edit_activo !== 1'b0) begin failures++; $display("FAIL reset_edit got=%b exp=0", bus.edit_activo); end
  endtask

  task automatic test_step_up;
    reset = 1'b0;
    tick;
    tick;
    checks++; if (bus.dseg !== 8'h15) begin failures++; $display("FAIL idle_copy got=%h exp=15", bus.dseg); end
    bus.seleccion = 1'b1;
    tick;
    checks++; if (bus.edit_activo !== 1'b1) begin failures++; $display("FAIL edit_enter got=%b exp=1", bus.edit_activo); end
    mdl_dseg = 8'h15;
    bus.dia_rtc = 8'h03;
    bus.btn_up = 1'b1;
    mdl_dseg = 8'h16;
    sb.push_back(mdl_dseg);
    tick;
    checks++; if (bus.ACT !== 1'b1 || bus.dseg !== 8'h16) begin failures++; $display("FAIL step_up got=%b/%h exp=1/16", bus.ACT, bus.dseg); end
    bus.btn_up = 1'b0;
    tick;
    checks++; if (bus.ACT !== 1'b0 || bus.dseg !== 8'h16) begin failures++; $display("FAIL act_one_cycle got=%b/%h exp=0/16", bus.ACT, bus.dseg); end
  endtask

  task automatic test_month_limit;
    logic [7:0] exp_v;
    bus.mes  = 8'h02;
    bus.anio = 8'h24;
    for (int i = 0; i < 40 && mdl_dseg != 8'h29; i++) press(1'b1);
`ifdef MES_LIMITE_EN
    exp_v = 8'h01;
`else
    exp_v = 8'h30;
`endif
    press(1'b1);
    checks++; if (bus.dseg !== exp_v) begin failures++; $display("FAIL leap_wrap got=%h exp=%h", bus.dseg, exp_v); end
    bus.anio = 8'h23;
    for (int i = 0; i < 40 && mdl_dseg != 8'h01; i++) press(1'b1);
`ifdef MES_LIMITE_EN
    exp_v = 8'h28;
`else
    exp_v = 8'h31;
`endif
    press(1'b0);
    checks++; if (bus.dseg !== exp_v) begin failures++; $display("FAIL down_wrap got=%h exp=%h", bus.dseg, exp_v); end
  endtask

  task automatic test_repeat;
    int hits[$];
    int exp_c[4];
    for (int i = 0; i < 40 && mdl_dseg != 8'h10; i++) press(1'b0);
    exp_c[0] = 1;
    exp_c[1] = 1 + RD;
    exp_c[2] = 1 + RD + RR;
    exp_c[3] = 1 + RD + 2 * RR;
    bus.btn_down = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mdl_dseg = mdl_step(mdl_dseg, 1'b0, mdl_max(bus.mes, bus.anio));
      sb.push_back(mdl_dseg);
    end
    for (int c = 1; c <= 20; c++) begin
      tick;
      if (bus.ACT === 1'b1) hits.push_back(c);
      if (c == 19) bus.btn_down = 1'b0;
    end
    tick;
    checks++; if (hits.size() != 4) begin failures++; $display("FAIL repeat_count got=%0d exp=4", hits.size()); end
    for (int k = 0; k < 4 && k < hits.size(); k++) begin
      checks++;
      if (hits[k] != exp_c[k]) begin failures++; $display("FAIL repeat_cycle%0d got=%0d exp=%0d", k, hits[k], exp_c[k]); end
    end
    checks++; if (bus.dseg !== 8'h06) begin failures++; $display("FAIL repeat_final got=%h exp=06", bus.dseg); end
  endtask

  task automatic test_both;
    int acts;
    acts = 0;
    bus.btn_up   = 1'b1;
    bus.btn_down = 1'b1;
    for (int c = 0; c < RD + 5; c++) begin
      tick;
      if (bus.ACT === 1'b1) acts++;
    end
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    tick;
    checks++; if (acts != 0) begin failures++; $display("FAIL both_act got=%0d exp=0", acts); end
    checks++; if (bus.dseg !== mdl_dseg) begin failures++; $display("FAIL both_dseg got=%h exp=%h", bus.dseg, mdl_dseg); end
  endtask

  task automatic test_write;
    for (int i = 0; i < 40 && mdl_dseg != 8'h20; i++) press(1'b1);
    bus.seleccion = 1'b0;
    bus.btn_up    = 1'b1;
    tick;
    checks++; if (bus.wr_req !== 1'b1 || bus.edit_activo !== 1'b0) begin failures++; $display("FAIL write_enter got=%b/%b exp=1/0", bus.wr_req, bus.edit_activo); end
    checks++; if (bus.dseg !== 8'h20 || bus.ACT !== 1'b0) begin failures++; $display("FAIL write_drop got=%h/%b exp=20/0", bus.dseg, bus.ACT); end
    bus.dia_rtc = 8'h07;
    for (int c = 0; c < 5; c++) begin
      bus.btn_up    = c[0];
      bus.seleccion = (c >= 1 && c <= 3);
      tick;
      checks++; if (bus.wr_req !== 1'b1 || bus.dseg !== 8'h20) begin failures++; $display("FAIL write_hold%0d got=%b/%h exp=1/20", c, bus.wr_req, bus.dseg); end
    end
    bus.btn_up    = 1'b0;
    bus.seleccion = 1'b0;
    bus.wr_ack    = 1'b1;
    tick;
    bus.wr_ack = 1'b0;
    checks++; if (bus.wr_req !== 1'b0) begin failures++; $display("FAIL write_ack got=%b exp=0", bus.wr_req); end
    tick;
    checks++; if (bus.dseg !== 8'h07 || bus.edit_activo !== 1'b0) begin failures++; $display("FAIL idle_track got=%h/%b exp=07/0", bus.dseg, bus.edit_activo); end
    bus.dia_rtc = 8'h22;
    tick;
    checks++; if (bus.dseg !== 8'h22) begin failures++; $display("FAIL idle_track2 got=%h exp=22", bus.dseg); end
  endtask

  task automatic test_reset_write;
    bus.seleccion = 1'b1;
    tick;
    bus.seleccion = 1'b0;
    tick;
    checks++; if (bus.wr_req !== 1'b1) begin failures++; $display("FAIL rw_enter got=%b exp=1", bus.wr_req); end
    reset = 1'b1;
    tick;
    checks++; if (bus.wr_req !== 1'b0 || bus.dseg !== 8'h01) begin failures++; $display("FAIL rw_reset got=%b/%h exp=0/01", bus.wr_req, bus.dseg); end
    checks++; if (bus.edit_activo !== 1'b0) begin failures++; $display("FAIL rw_edit got=%b exp=0", bus.edit_activo); end
    reset = 1'b0;
    bus.dia_rtc = 8'h11;
    tick;
    checks++; if (bus.dseg !== 8'h11 || bus.wr_req !== 1'b0) begin failures++; $display("FAIL rw_idle got=%h/%b exp=11/0", bus.dseg, bus.wr_req); end
  endtask

  initial begin
    test_reset;
    test_step_up;
    test_month_limit;
    test_repeat;
    test_both;
    test_write;
    test_reset_write;
    tick;
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/editor_dia_bcd.md
EDITOR_DIA_BCD -- requirements
Module: editor_dia_bcd

Interface
REQ-001 SHALL have parameter REPEAT_DELAY, default 50_000_000, cycles a button is held before auto-repeat starts.
REQ-002 SHALL have parameter REPEAT_RATE, default 10_000_000, cycles between auto-repeat steps.
REQ-003 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port seleccion  in  1  1 = user programming mode, 0 = RTC display mode.
REQ-006 SHALL have ports btn_up, btn_down  in  1 each  debounced, synchronous, level-high buttons.
REQ-007 SHALL have port dia_rtc  in  8  current day from RTC, BCD 01..31.
REQ-008 SHALL have ports mes, anio  in  8 each  current month and year, BCD.
REQ-009 SHALL have port wr_ack  in  1  RTC writer accepted the write.
REQ-010 SHALL have port dseg  out  8  day value, BCD, for the day display register.
REQ-011 SHALL have port ACT  out  1  one-cycle strobe: dseg changed by the user.
REQ-012 SHALL have port wr_req  out  1  request to write dseg back to the RTC.
REQ-013 SHALL have port edit_activo  out  1  high in EDIT state.

Function
REQ-014 SHALL implement FSM IDLE, EDIT, WRITE.
REQ-015 IDLE: SHALL copy dia_rtc into dseg every cycle, with ACT=0 and wr_req=0.
REQ-016 IDLE->EDIT SHALL occur when seleccion=1; dseg then holds the last value copied.
REQ-017 EDIT: a rising edge on exactly one button SHALL step dseg once; holding it REPEAT_DELAY cycles SHALL step again, then every REPEAT_RATE cycles until release.
REQ-018 Both buttons high in the same cycle SHALL cause no step and SHALL reset both repeat counters.
REQ-019 Step up SHALL be BCD increment; max -> 01. Step down SHALL be BCD decrement; 01 -> max.
REQ-020 If dseg > max (e.g. month changed), step up SHALL yield 01 and step down SHALL yield max.
REQ-021 The new dseg value and ACT=1 SHALL appear together one cycle after the step is detected; ACT SHALL be low otherwise.
REQ-022 EDIT->WRITE SHALL occur when seleccion=0; a step detected in that same cycle SHALL be dropped.
REQ-023 WRITE: wr_req SHALL be 1 and dseg SHALL be held stable; buttons and seleccion SHALL be ignored.
REQ-024 WRITE->IDLE SHALL occur on the cycle wr_ack=1 is sampled; wr_req SHALL be 0 from the next cycle.
REQ-025 dseg SHALL never hold a non-BCD digit or 00 after the first step.

Reset
REQ-026 reset SHALL force state IDLE, dseg=8'h01, ACT=0, wr_req=0, edit_activo=0, and clear repeat counters and edge registers.
REQ-027 reset in any state, including mid-WRITE, SHALL abandon the operation with no write completed.

Configuration
REQ-028 With macro MES_LIMITE_EN defined, max SHALL be 31 for months 01,03,05,07,08,10,12; 30 for 04,06,09,11; 29 for 02 when anio mod 4 = 0 (BCD), else 28; 31 for an invalid month.
REQ-029 Without MES_LIMITE_EN, max SHALL be 31 always, and mes/anio SHALL be unused.

Structure
REQ-030 A shared package SHALL hold the state encoding, BCD constants 8'h01/8'h28/8'h29/8'h30/8'h31, and the month-limit function.
REQ-031 A sub-module repetidor_boton (edge detect plus auto-repeat counter, outputs a step pulse) SHALL be instantiated once per button.

Verification
REQ-032 Reset, dia_rtc=8'h15, seleccion=1, btn_up pulse -> dseg=8'h16 with ACT=1 for exactly one cycle.
REQ-033 mes=8'h02, anio=8'h24, dseg=8'h29, btn_up -> 8'h01; anio=8'h23, dseg=8'h01, btn_down -> 8'h28 (MES_LIMITE_EN defined); without the macro -> 8'h31.
REQ-034 btn_down held with REPEAT_DELAY=10, REPEAT_RATE=3 from 8'h10 -> steps at press+1, +11, +14, +17 cycles; values 09, 08, 07, 06.
REQ-035 btn_up and btn_down high together -> dseg unchanged, ACT=0.
REQ-036 seleccion 1->0 with dseg=8'h20 -> wr_req=1 held; wr_ack pulse after 5 cycles -> wr_req=0 next cycle, IDLE, dseg tracks dia_rtc.
REQ-037 reset during WRITE -> wr_req=0 and dseg=8'h01 on the next cycle.
